input_stream_node: RTL and testbench
====================================

INPUT_STREAM_NODE -- requirements
Module: input_stream_node

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of stream and memory read data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, response buffer entries; legal values are powers of two, 2 or greater.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, single-cycle transfer start.
REQ-006 SHALL have port base_addr_i, input, 32, byte address of the first word.
REQ-007 SHALL have port size_i, input, 16, number of words to read.
REQ-008 SHALL have port stride_i, input, 16, unsigned byte increment between words.
REQ-009 SHALL have port busy_o, output, 1, transfer in progress.
REQ-010 SHALL have port done_o, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port mem_req_o, output, 1, memory read request.
REQ-012 SHALL have port mem_addr_o, output, 32, request address.
REQ-013 SHALL have port mem_gnt_i, input, 1, request accepted.
REQ-014 SHALL have port mem_rvalid_i, input, 1, read response valid.
REQ-015 SHALL have port mem_rdata_i, input, DATA_WIDTH, read response data.
REQ-016 SHALL have port dout_o, output, DATA_WIDTH, stream data to the processing cell's din.
REQ-017 SHALL have port dout_v_o, output, 1, stream valid.
REQ-018 SHALL have port dout_r_i, input, 1, stream ready from the consumer.

Function
REQ-019 SHALL implement states IDLE, REQ and DRAIN; busy_o SHALL be high exactly in REQ and DRAIN.
REQ-020 In IDLE, start_i with size_i!=0 SHALL latch base_addr_i, size_i and stride_i, clear req_cnt and outstanding, and enter REQ next cycle.
REQ-021 In IDLE, start_i with size_i==0 SHALL pulse done_o the next cycle and stay in IDLE, issuing no request.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 In REQ, mem_req_o SHALL be high iff req_cnt<size and fifo_count+outstanding<FIFO_DEPTH, so responses can never overflow the FIFO.
REQ-024 mem_addr_o SHALL equal base+req_cnt*stride modulo 2^32, produced by an accumulator.
REQ-025 Once raised, mem_req_o and mem_addr_o SHALL hold stable until mem_gnt_i is sampled high.
REQ-026 req&gnt SHALL increment req_cnt and outstanding; mem_rvalid_i SHALL push mem_rdata_i and decrement outstanding; both in one cycle SHALL leave outstanding unchanged.
REQ-027 mem_rvalid_i while outstanding==0 SHALL be dropped with no state change.
REQ-028 When req_cnt reaches size, the state SHALL go to DRAIN; in DRAIN mem_req_o SHALL be 0.
REQ-029 DRAIN SHALL exit to IDLE when outstanding==0 and the FIFO is empty; done_o SHALL pulse one cycle on that transition.
REQ-030 dout_v_o SHALL be 1 iff the FIFO is non-empty, and dout_o SHALL be the FIFO head; a pop SHALL occur only when dout_v_o&dout_r_i.
REQ-031 Data accepted with mem_rvalid_i in cycle t SHALL first be visible on dout_o/dout_v_o in cycle t+1.
REQ-032 The FIFO SHALL support a simultaneous push and pop in the same cycle at any occupancy.
REQ-033 Words SHALL leave in request order, and dout_o SHALL hold stable while dout_v_o&!dout_r_i.

Reset
REQ-034 rst_i high at a clock edge SHALL force IDLE, empty the FIFO, and zero req_cnt, outstanding and the address accumulator.
REQ-035 During and after reset, busy_o, done_o, mem_req_o and dout_v_o SHALL be 0, and mem_addr_o SHALL be 0.
REQ-036 Reset mid-transfer SHALL abandon the transfer without a done_o pulse; late responses SHALL be dropped per REQ-027.

Verification
REQ-037 base=0x1000, size=4, stride=4, gnt=1, rvalid one cycle after gnt, dout_r=1 -> addresses 0x1000/0x1004/0x1008/0x100C, four words in order, one done_o pulse.
REQ-038 size=8, FIFO_DEPTH=4, dout_r=0 -> exactly 4 grants, then mem_req_o=0; after dout_r=1 the remaining 4 words complete and done_o pulses.
REQ-039 gnt=0 for 3 cycles on the first request -> mem_req_o=1 and mem_addr_o=0x1000 held stable for all 3 cycles.
REQ-040 base=0xFFFFFFF8, stride=8, size=3 -> addresses 0xFFFFFFF8, 0x00000000, 0x00000008.
REQ-041 size=0 start -> done_o one cycle later, mem_req_o never asserted.
REQ-042 rst_i after 2 of 6 grants -> next cycle all outputs 0; stray rvalid ignored; a new start runs cleanly from req_cnt 0.

Source files
------------

// File: rtl/input_stream_node.sv
// input_stream_node: strided memory reader that streams read responses through a credit-limited FIFO.
module input_stream_node #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [15:0]           size_i,
  input  logic [15:0]           stride_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic [31:0]           mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_v_o,
  input  logic                  dout_r_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state;
  logic [31:0] addr;
  logic [15:0] size, stride, req_cnt;
  logic [AW:0] outstanding, count;
  logic [AW+1:0] occ;
  logic [AW-1:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic done, gnt, push, pop;
  // Buffered plus in-flight words are bounded by the depth, so a response always has a slot.
  assign occ = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_o = state == REQ && req_cnt < size && occ < (AW+2)'(FIFO_DEPTH);
  assign gnt = mem_req_o & mem_gnt_i;
  assign push = mem_rvalid_i && outstanding != '0;
  assign dout_v_o = count != '0;
  assign pop = dout_v_o & dout_r_i;
  assign dout_o = mem[rptr];
  assign busy_o = state != IDLE;
  assign done_o = done;
  assign mem_addr_o = addr;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      addr <= '0;
      size <= '0;
      stride <= '0;
      req_cnt <= '0;
      outstanding <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      outstanding <= outstanding + (AW+1)'(gnt) - (AW+1)'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) begin
        mem[wptr] <= mem_rdata_i;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case (state)
        IDLE: if (start_i) begin
          if (size_i == '0) done <= 1'b1;
          else begin
            state <= REQ;
            addr <= base_addr_i;
            size <= size_i;
            stride <= stride_i;
            req_cnt <= '0;
            outstanding <= '0;
          end
        end
        REQ: if (gnt) begin
          addr <= addr + {16'b0, stride};
          req_cnt <= req_cnt + 16'd1;
          if (req_cnt + 16'd1 == size) state <= DRAIN;
        end
        default: if (outstanding == '0 && count == '0) begin
          state <= IDLE;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_stream_node.sv
// tb_input_stream_node: directed checks of the strided stream reader against a simple memory responder.
module tb_input_stream_node;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] size_i = '0, stride_i = '0;
  logic busy_o, done_o, mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, dout_v_o, dout_r_i = 1'b0;
  logic [31:0] mem_addr_o, mem_rdata_i = '0, dout_o;
  logic stray = 1'b0;
  int tests = 0, fails = 0, gnt_cnt = 0, done_cnt = 0, req_cyc = 0;
  logic [31:0] gnt_q[$], rx_q[$];
  int g0, r0, d0, q0;

  input_stream_node #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .size_i(size_i), .stride_i(stride_i), .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .dout_o(dout_o),
    .dout_v_o(dout_v_o), .dout_r_i(dout_r_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory answers every grant one cycle later with addr ^ 0x5A5A0000; also logs grants, pops and done pulses.
  initial begin
    logic fire;
    logic [31:0] faddr;
    forever begin
      @(negedge clk_i);
      fire = mem_req_o & mem_gnt_i;
      faddr = mem_addr_o;
      if (fire) begin
        gnt_cnt++;
        gnt_q.push_back(faddr);
      end
      if (mem_req_o) req_cyc++;
      if (dout_v_o & dout_r_i) rx_q.push_back(dout_o);
      if (done_o) done_cnt++;
      @(posedge clk_i);
      #2;
      mem_rvalid_i = fire | stray;
      mem_rdata_i = fire ? (faddr ^ 32'h5A5A_0000) : 32'hDEAD_BEEF;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] b, input logic [15:0] s, input logic [15:0] st);
    base_addr_i = b;
    size_i = s;
    stride_i = st;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d, input string tag);
    int n = 0;
    while (done_cnt == d && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt - d), 32'd1);
  endtask

  initial begin
    tick(2);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_dout_v", {31'b0, dout_v_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // basic four-word transfer
    mem_gnt_i = 1'b1;
    dout_r_i = 1'b1;
    g0 = gnt_q.size(); r0 = rx_q.size(); d0 = done_cnt;
    start(32'h1000, 16'd4, 16'd4);
    check("t1_busy", {31'b0, busy_o}, 32'd1);
    check("t1_req", {31'b0, mem_req_o}, 32'd1);
    check("t1_addr0", mem_addr_o, 32'h1000);
    wait_done(d0, "t1_done");
    tick(2);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_busy_end", {31'b0, busy_o}, 32'd0);
    check("t1_ngnt", 32'(gnt_q.size() - g0), 32'd4);
    check("t1_a0", gnt_q[g0], 32'h1000);
    check("t1_a1", gnt_q[g0+1], 32'h1004);
    check("t1_a2", gnt_q[g0+2], 32'h1008);
    check("t1_a3", gnt_q[g0+3], 32'h100C);
    check("t1_nrx", 32'(rx_q.size() - r0), 32'd4);
    check("t1_w0", rx_q[r0], 32'h5A5A1000);
    check("t1_w1", rx_q[r0+1], 32'h5A5A1004);
    check("t1_w2", rx_q[r0+2], 32'h5A5A1008);
    check("t1_w3", rx_q[r0+3], 32'h5A5A100C);

    // back-pressure: only FIFO_DEPTH grants while the consumer stalls
    dout_r_i = 1'b0;
    q0 = gnt_cnt; r0 = rx_q.size(); d0 = done_cnt;
    start(32'h2000, 16'd8, 16'd4);
    tick(15);
    check("t2_ngnt_stall", 32'(gnt_cnt - q0), 32'd4);
    check("t2_req_low", {31'b0, mem_req_o}, 32'd0);
    check("t2_dout_v", {31'b0, dout_v_o}, 32'd1);
    check("t2_head", dout_o, 32'h5A5A2000);
    tick();
    check("t2_head_hold", dout_o, 32'h5A5A2000);
    dout_r_i = 1'b1;
    wait_done(d0, "t2_done");
    check("t2_ngnt", 32'(gnt_cnt - q0), 32'd8);
    check("t2_nrx", 32'(rx_q.size() - r0), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_w%0d", i), rx_q[r0+i], 32'h5A5A2000 + 32'(4*i));

    // grant withheld: request and address hold
    mem_gnt_i = 1'b0;
    q0 = gnt_cnt; r0 = rx_q.size(); d0 = done_cnt;
    start(32'h1000, 16'd1, 16'd4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_req_c%0d", i), {31'b0, mem_req_o}, 32'd1);
      check($sformatf("t3_addr_c%0d", i), mem_addr_o, 32'h1000);
      tick();
    end
    check("t3_nogrant", 32'(gnt_cnt - q0), 32'd0);
    mem_gnt_i = 1'b1;
    wait_done(d0, "t3_done");
    check("t3_w0", rx_q[r0], 32'h5A5A1000);

    // 32-bit address wrap
    g0 = gnt_q.size(); d0 = done_cnt;
    start(32'hFFFF_FFF8, 16'd3, 16'd8);
    wait_done(d0, "t4_done");
    check("t4_a0", gnt_q[g0], 32'hFFFF_FFF8);
    check("t4_a1", gnt_q[g0+1], 32'h0000_0000);
    check("t4_a2", gnt_q[g0+2], 32'h0000_0008);

    // zero-size start
    tick();
    q0 = req_cyc; d0 = done_cnt;
    start(32'h5000, 16'd0, 16'd4);
    check("t5_done", {31'b0, done_o}, 32'd1);
    check("t5_busy", {31'b0, busy_o}, 32'd0);
    tick();
    check("t5_done_clr", {31'b0, done_o}, 32'd0);
    tick(2);
    check("t5_noreq", 32'(req_cyc - q0), 32'd0);
    check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

    // reset after two grants of six
    q0 = gnt_cnt;
    start(32'h3000, 16'd6, 16'd4);
    for (int n = 0; n < 50 && gnt_cnt - q0 < 2; n++) tick();
    check("t6_two_grants", 32'(gnt_cnt - q0), 32'd2);
    d0 = done_cnt;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_busy", {31'b0, busy_o}, 32'd0);
    check("t6_done", {31'b0, done_o}, 32'd0);
    check("t6_req", {31'b0, mem_req_o}, 32'd0);
    check("t6_dout_v", {31'b0, dout_v_o}, 32'd0);
    check("t6_addr", mem_addr_o, 32'd0);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick(2);
    check("t6_stray_dropped", {31'b0, dout_v_o}, 32'd0);
    check("t6_idle", {31'b0, busy_o}, 32'd0);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    g0 = gnt_q.size(); r0 = rx_q.size(); d0 = done_cnt;
    start(32'h4000, 16'd2, 16'd4);
    check("t6_restart_addr", mem_addr_o, 32'h4000);
    wait_done(d0, "t6_done_new");
    check("t6_ngnt", 32'(gnt_q.size() - g0), 32'd2);
    check("t6_a1", gnt_q[g0+1], 32'h4004);
    check("t6_nrx", 32'(rx_q.size() - r0), 32'd2);
    check("t6_w0", rx_q[r0], 32'h5A5A4000);
    check("t6_w1", rx_q[r0+1], 32'h5A5A4004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
